uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter with an on-chip baud-rate generator and a small

---
 rtl/uart_tx_fifo.sv | 137 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with baud-rate enable and transmit FIFO
module uart_tx_fifo #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          hw_clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          LAST_STP = 1'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: DIV must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                  state_q, state_d;
    logic [DATA_BITS-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [AW:0]             count_q;
    logic [DATA_BITS-1:0]    shift_q;
    logic [CW-1:0]           baud_q;
    logic [BW-1:0]           bit_q;
    logic                    stop_q;
    logic                    par_q;
    logic                    tx_q;
    logic                    push, pop, tick, last_bit, last_stop;

    assign tx_ready   = (count_q != (AW+1)'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign tick       = (baud_q == DIV_M1);
    assign last_bit   = (bit_q == LAST_BIT);
    assign last_stop  = (stop_q == LAST_STP);
    assign tx         = tx_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:  if (count_q != '0) begin
                       pop     = 1'b1;
                       state_d = START;
                   end
            START: if (tick) state_d = DATA;
            DATA:  if (tick && last_bit) state_d = (PARITY != 0) ? PAR : STOP;
            PAR:   if (tick) state_d = STOP;
            STOP:  if (tick && last_stop) begin
                       // Chain straight into the next start bit when data is waiting
                       if (count_q != '0) begin
                           pop     = 1'b1;
                           state_d = START;
                       end else begin
                           state_d = IDLE;
                       end
                   end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hw_clk) begin
        if (push) mem[wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else if (pop) begin
            shift_q <= mem[rd_ptr_q];
            par_q   <= (PARITY == 1) ? ~^mem[rd_ptr_q] : ^mem[rd_ptr_q];
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b0;
        end else if (state_q != IDLE) begin
            baud_q <= tick ? '0 : baud_q + 1'b1;
            if (tick) begin
                case (state_q)
                    START: tx_q <= shift_q[0];
                    DATA:  if (last_bit) begin
                               tx_q <= (PARITY != 0) ? par_q : 1'b1;
                           end else begin
                               shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                               tx_q    <= shift_q[1];
                               bit_q   <= bit_q + 1'b1;
                           end
                    PAR:   tx_q   <= 1'b1;
                    STOP:  stop_q <= stop_q + 1'b1;
                    default: tx_q <= 1'b1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo across several parameter sets
module tb_uart_tx_fifo;
    logic            hw_clk = 1'b0;
    logic            rst    = 1'b1;
    logic [4:0]      valid  = '0;
    logic [4:0][8:0] data   = '0;
    wire  [4:0]      ready, txs, busy;
    wire  [4:0][2:0] cnt;
    int              sel = 0;
    logic            tx_mon;
    int              checks = 0;
    int              passed = 0;

    always #5 hw_clk = ~hw_clk;
    always_comb tx_mon = txs[sel];

    // 0: defaults (DIV 1250); 1: 8N1 DIV 10; 2: even/2 stop DIV 10; 3: odd/2 stop DIV 10; 4: 7N1 DIV 104
    uart_tx_fifo u_main (.hw_clk(hw_clk), .rst(rst), .tx_data(data[0][7:0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx(txs[0]), .busy(busy[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLK_HZ(96000)) u_fast (.hw_clk(hw_clk), .rst(rst), .tx_data(data[1][7:0]),
        .tx_valid(valid[1]), .tx_ready(ready[1]), .tx(txs[1]), .busy(busy[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLK_HZ(96000), .PARITY(2), .STOP_BITS(2)) u_even (.hw_clk(hw_clk), .rst(rst),
        .tx_data(data[2][7:0]), .tx_valid(valid[2]), .tx_ready(ready[2]), .tx(txs[2]),
        .busy(busy[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.CLK_HZ(96000), .PARITY(1), .STOP_BITS(2)) u_odd (.hw_clk(hw_clk), .rst(rst),
        .tx_data(data[3][7:0]), .tx_valid(valid[3]), .tx_ready(ready[3]), .tx(txs[3]),
        .busy(busy[3]), .fifo_count(cnt[3]));
    uart_tx_fifo #(.DATA_BITS(7), .BAUD(115200)) u_seven (.hw_clk(hw_clk), .rst(rst),
        .tx_data(data[4][6:0]), .tx_valid(valid[4]), .tx_ready(ready[4]), .tx(txs[4]),
        .busy(busy[4]), .fifo_count(cnt[4]));

    task automatic push_byte(input int idx, input logic [8:0] d);
        data[idx]  = d;
        valid[idx] = 1'b1;
        @(negedge hw_clk);
        valid[idx] = 1'b0;
    endtask

    // Samples tx_mon for nbits windows of div cycles; stable=0 if any window changes level
    task automatic collect(input int div, input int nbits, output logic [63:0] lv, output bit stable);
        logic v;
        lv = '0;
        stable = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge hw_clk);
                v = tx_mon;
                if (c == 0) lv[b] = v;
                else if (v !== lv[b]) stable = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge hw_clk);
        rst = 1'b0;
        @(negedge hw_clk);
        for (int i = 0; i < 5; i++) begin
            checks++; if (txs[i] !== 1'b1) $display("FAIL reset_tx[%0d] got %b want 1", i, txs[i]); else passed++;
            checks++; if (ready[i] !== 1'b1) $display("FAIL reset_ready[%0d] got %b want 1", i, ready[i]); else passed++;
            checks++; if (busy[i] !== 1'b0) $display("FAIL reset_busy[%0d] got %b want 0", i, busy[i]); else passed++;
            checks++; if (cnt[i] !== 3'd0) $display("FAIL reset_count[%0d] got %0d want 0", i, cnt[i]); else passed++;
        end
    endtask

    task automatic test_single_frame;
        logic [63:0] lv;
        bit st;
        sel = 0;
        push_byte(0, 9'h061);
        checks++; if (txs[0] !== 1'b1) $display("FAIL latency_tx got %b want 1", txs[0]); else passed++;
        checks++; if (cnt[0] !== 3'd1) $display("FAIL push_count got %0d want 1", cnt[0]); else passed++;
        checks++; if (busy[0] !== 1'b1) $display("FAIL push_busy got %b want 1", busy[0]); else passed++;
        data[0] = 9'h0FF;
        collect(1250, 10, lv, st);
        checks++; if (lv[9:0] !== 10'b1_0110_0001_0) $display("FAIL frame_61 got %b want %b", lv[9:0], 10'b1_0110_0001_0); else passed++;
        checks++; if (st !== 1'b1) $display("FAIL frame_61_timing got %b want 1", st); else passed++;
        checks++; if (busy[0] !== 1'b1) $display("FAIL busy_last_stop got %b want 1", busy[0]); else passed++;
        @(negedge hw_clk);
        checks++; if (busy[0] !== 1'b0) $display("FAIL busy_after_12500 got %b want 0", busy[0]); else passed++;
        checks++; if (txs[0] !== 1'b1) $display("FAIL idle_tx got %b want 1", txs[0]); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] lv, exp;
        bit st, r;
        int sent, guard;
        sel = 1;
        sent = 0;
        exp = '0;
        for (int i = 0; i < 6; i++) exp[10*i +: 10] = {1'b1, 8'(i), 1'b0};
        data[1]  = 9'h000;
        valid[1] = 1'b1;
        fork
            begin
                guard = 0;
                while (sent < 6 && guard < 400) begin
                    r = ready[1];
                    @(negedge hw_clk);
                    guard++;
                    if (r) begin
                        sent++;
                        if (sent == 5) begin
                            checks++; if (cnt[1] !== 3'd4) $display("FAIL full_count got %0d want 4", cnt[1]); else passed++;
                            checks++; if (ready[1] !== 1'b0) $display("FAIL full_ready got %b want 0", ready[1]); else passed++;
                        end
                        if (sent < 6) data[1] = 9'(sent);
                        else valid[1] = 1'b0;
                    end
                end
                valid[1] = 1'b0;
            end
            begin
                @(negedge hw_clk);
                collect(10, 60, lv, st);
            end
        join
        checks++; if (sent != 6) $display("FAIL b2b_pushes got %0d want 6", sent); else passed++;
        checks++; if (lv[59:0] !== exp[59:0]) $display("FAIL b2b_frames got %h want %h", lv[59:0], exp[59:0]); else passed++;
        checks++; if (st !== 1'b1) $display("FAIL b2b_timing got %b want 1", st); else passed++;
        @(negedge hw_clk);
        checks++; if (busy[1] !== 1'b0) $display("FAIL b2b_busy_end got %b want 0", busy[1]); else passed++;
        checks++; if (cnt[1] !== 3'd0) $display("FAIL b2b_count_end got %0d want 0", cnt[1]); else passed++;
    endtask

    task automatic test_parity;
        logic [63:0] lv;
        bit st;
        sel = 2;
        push_byte(2, 9'h007);
        collect(10, 12, lv, st);
        checks++; if (lv[11:0] !== {3'b111, 8'h07, 1'b0}) $display("FAIL even_frame got %b want %b", lv[11:0], {3'b111, 8'h07, 1'b0}); else passed++;
        checks++; if (st !== 1'b1) $display("FAIL even_timing got %b want 1", st); else passed++;
        checks++; if (busy[2] !== 1'b1) $display("FAIL even_busy_stop got %b want 1", busy[2]); else passed++;
        @(negedge hw_clk);
        checks++; if (busy[2] !== 1'b0) $display("FAIL even_busy_end got %b want 0", busy[2]); else passed++;
        sel = 3;
        push_byte(3, 9'h007);
        collect(10, 12, lv, st);
        checks++; if (lv[11:0] !== {3'b110, 8'h07, 1'b0}) $display("FAIL odd_frame got %b want %b", lv[11:0], {3'b110, 8'h07, 1'b0}); else passed++;
        checks++; if (st !== 1'b1) $display("FAIL odd_timing got %b want 1", st); else passed++;
        @(negedge hw_clk);
        checks++; if (busy[3] !== 1'b0) $display("FAIL odd_busy_end got %b want 0", busy[3]); else passed++;
    endtask

    task automatic test_reset_mid_frame;
        logic [63:0] lv;
        bit st;
        sel = 0;
        push_byte(0, 9'h000);
        push_byte(0, 9'h0AA);
        repeat (5600) @(negedge hw_clk);
        checks++; if (txs[0] !== 1'b0) $display("FAIL bit3_tx got %b want 0", txs[0]); else passed++;
        checks++; if (cnt[0] !== 3'd1) $display("FAIL bit3_count got %0d want 1", cnt[0]); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (txs[0] !== 1'b1) $display("FAIL async_tx got %b want 1", txs[0]); else passed++;
        checks++; if (cnt[0] !== 3'd0) $display("FAIL async_count got %0d want 0", cnt[0]); else passed++;
        checks++; if (busy[0] !== 1'b0) $display("FAIL async_busy got %b want 0", busy[0]); else passed++;
        repeat (2) @(negedge hw_clk);
        rst = 1'b0;
        @(negedge hw_clk);
        checks++; if (txs[0] !== 1'b1) $display("FAIL post_reset_tx got %b want 1", txs[0]); else passed++;
        push_byte(0, 9'h055);
        collect(1250, 10, lv, st);
        checks++; if (lv[9:0] !== {1'b1, 8'h55, 1'b0}) $display("FAIL frame_55 got %b want %b", lv[9:0], {1'b1, 8'h55, 1'b0}); else passed++;
        checks++; if (st !== 1'b1) $display("FAIL frame_55_timing got %b want 1", st); else passed++;
        @(negedge hw_clk);
        checks++; if (busy[0] !== 1'b0) $display("FAIL frame_55_busy_end got %b want 0", busy[0]); else passed++;
    endtask

    task automatic test_seven_bits;
        logic [63:0] lv;
        bit st;
        sel = 4;
        push_byte(4, 9'h07F);
        collect(104, 9, lv, st);
        checks++; if (lv[8:0] !== 9'b1_1111111_0) $display("FAIL seven_frame got %b want %b", lv[8:0], 9'b1_1111111_0); else passed++;
        checks++; if (st !== 1'b1) $display("FAIL seven_timing got %b want 1", st); else passed++;
        checks++; if (busy[4] !== 1'b1) $display("FAIL seven_busy_stop got %b want 1", busy[4]); else passed++;
        @(negedge hw_clk);
        checks++; if (busy[4] !== 1'b0) $display("FAIL seven_busy_936 got %b want 0", busy[4]); else passed++;
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_parity;
        test_reset_mid_frame;
        test_seven_bits;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
